param_shift_reg: RTL and testbench



---
 rtl/param_shift_reg.sv | 186 ++++++++++++++++++
 tb/tb_param_shift_reg.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/param_shift_reg.sv
// WIDTH-bit storage/shift element with set, parallel load, shift/rotate modes
// and an autonomous burst-rotate engine that pulses done when it finishes.

module param_shift_reg_bit (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] mode,
    input  logic       d,
    input  logic       lo,
    input  logic       hi,
    input  logic       set_val,
    output logic       q
);
    localparam logic [2:0] M_HOLD = 3'd0;
    localparam logic [2:0] M_LOAD = 3'd1;
    localparam logic [2:0] M_UP   = 3'd2;
    localparam logic [2:0] M_DN   = 3'd3;
    localparam logic [2:0] M_SET  = 3'd4;

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            case (mode)
                M_LOAD:  q <= d;
                M_UP:    q <= lo;
                M_DN:    q <= hi;
                M_SET:   q <= set_val;
                M_HOLD:  q <= q;
                default: q <= q;
            endcase
        end
    end
endmodule

module param_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 4,
    parameter logic [WIDTH-1:0] SET_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             dir,
    input  logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);
    localparam logic [2:0] M_HOLD = 3'd0;
    localparam logic [2:0] M_LOAD = 3'd1;
    localparam logic [2:0] M_UP   = 3'd2;
    localparam logic [2:0] M_DN   = 3'd3;
    localparam logic [2:0] M_SET  = 3'd4;

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_BURST = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic             dir_r;

    logic [2:0]       mode;
    logic             rot;
    logic             lo_fill;
    logic             hi_fill;
    logic [WIDTH-1:0] lo_vec;
    logic [WIDTH-1:0] hi_vec;

    // Every bit sees the same mode; only the fill at each end differs
    // between shift (serial input) and rotate (wrapped bit).
    always_comb begin
        mode = M_HOLD;
        rot  = 1'b0;
        if (set) begin
            mode = M_SET;
        end else if (state == S_BURST) begin
            if (remaining != '0) begin
                rot  = 1'b1;
                mode = dir_r ? M_DN : M_UP;
            end
        end else if (state == S_IDLE && en) begin
            case (op)
                OP_LOAD: mode = M_LOAD;
                OP_SHL:  mode = M_UP;
                OP_SHR:  mode = M_DN;
                OP_ROL:  begin mode = M_UP; rot = 1'b1; end
                OP_ROR:  begin mode = M_DN; rot = 1'b1; end
                default: mode = M_HOLD;
            endcase
        end
    end

    assign lo_fill = rot ? q[WIDTH-1] : sin_r;
    assign hi_fill = rot ? q[0]       : sin_l;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            if (i == 0) begin : g_lo_end
                assign lo_vec[i] = lo_fill;
            end else begin : g_lo_mid
                assign lo_vec[i] = q[i-1];
            end
            if (i == WIDTH-1) begin : g_hi_end
                assign hi_vec[i] = hi_fill;
            end else begin : g_hi_mid
                assign hi_vec[i] = q[i+1];
            end
            param_shift_reg_bit u_bit (
                .clock   (clock),
                .reset   (reset),
                .mode    (mode),
                .d       (d[i]),
                .lo      (lo_vec[i]),
                .hi      (hi_vec[i]),
                .set_val (SET_VALUE[i]),
                .q       (q[i])
            );
        end
    endgenerate

    // busy/done are registered alongside the state so they never glitch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            remaining <= '0;
            dir_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (set) begin
            state     <= S_IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en && op == OP_BURST) begin
                        state     <= S_BURST;
                        remaining <= cnt;
                        dir_r     <= dir;
                        busy      <= 1'b1;
                    end
                    done <= 1'b0;
                end
                S_BURST: begin
                    if (remaining != '0) begin
                        remaining <= remaining - 1'b1;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                    busy <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];
endmodule

// File: tb/tb_param_shift_reg.sv
// Directed bench for param_shift_reg: single-step ops, burst timing, aborts.

module tb_param_shift_reg;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset, set, en, sin_l, sin_r, dir;
    logic [2:0]       op;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q;
    logic             sout_l, sout_r, busy, done;

    int n_chk  = 0;
    int n_fail = 0;

    param_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .set(set), .en(en), .op(op), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .dir(dir), .cnt(cnt),
        .q(q), .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change #1 after the rising edge; checks happen there too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_op(input logic [2:0] o, input logic [7:0] dv);
        en = 1'b1; op = o; d = dv;
        tick();
        en = 1'b0; op = 3'b000;
    endtask

    task automatic start_burst(input logic dr, input logic [CNT_W-1:0] c);
        en = 1'b1; op = 3'b110; dir = dr; cnt = c;
        tick();
        en = 1'b0; op = 3'b000;
    endtask

    initial begin
        reset = 1'b1; set = 1'b0; en = 1'b0; op = 3'b000; d = '0;
        sin_l = 1'b0; sin_r = 1'b0; dir = 1'b0; cnt = '0;
        #1;
        tick(); tick();
        check("reset_q", q, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        reset = 1'b0;

        do_op(3'b001, 8'hA5);
        check("load_q", q, 8'hA5);
        check("load_busy", busy, 0);
        check("load_done", done, 0);

        reset = 1'b1; set = 1'b1; tick(); reset = 1'b0; set = 1'b0;
        check("reset_over_set", q, 8'h00);

        do_op(3'b001, 8'hA5);
        sin_r = 1'b1; do_op(3'b010, 8'h00); sin_r = 1'b0;
        check("shl_q", q, 8'h4B);
        check("shl_sout_l", sout_l, 0);
        check("shl_sout_r", sout_r, 1);
        sin_l = 1'b0; do_op(3'b011, 8'h00);
        check("shr_q", q, 8'h25);
        do_op(3'b100, 8'h00);
        check("rol_q", q, 8'h4A);
        check("rol_sout_r", sout_r, 0);
        do_op(3'b101, 8'h00);
        check("ror_q", q, 8'h25);
        check("ror_sout_r", sout_r, 1);

        // Burst left by 3 on 0x81.
        do_op(3'b001, 8'h81);
        start_burst(1'b0, 4'd3);
        check("b3_start_busy", busy, 1);
        check("b3_start_q", q, 8'h81);
        tick(); check("b3_r1", q, 8'h03);
        tick(); check("b3_r2", q, 8'h06);
        tick(); check("b3_r3", q, 8'h0C);
        check("b3_r3_done", done, 0);
        tick(); check("b3_done", done, 1);
        check("b3_done_busy", busy, 1);
        check("b3_done_q", q, 8'h0C);
        tick(); check("b3_idle_done", done, 0);
        check("b3_idle_busy", busy, 0);

        // Zero-length burst still passes through DONE.
        start_burst(1'b1, 4'd0);
        check("b0_busy", busy, 1);
        tick(); check("b0_done", done, 1);
        check("b0_q", q, 8'h0C);
        tick(); check("b0_after_done", done, 0);
        check("b0_after_busy", busy, 0);

        // Right by 8 on 0x3C wraps back; a LOAD held during the burst is ignored.
        do_op(3'b001, 8'h3C);
        start_burst(1'b1, 4'd8);
        en = 1'b1; op = 3'b001; d = 8'h00;
        tick(); check("b8_r1", q, 8'h1E);
        for (int k = 2; k <= 8; k++) begin
            tick();
            check("b8_busy", busy, 1);
            check("b8_nodone", done, 0);
        end
        check("b8_q", q, 8'h3C);
        tick(); check("b8_done", done, 1);
        check("b8_done_q", q, 8'h3C);
        en = 1'b0; op = 3'b000;
        tick(); check("b8_idle", busy, 0);
        check("b8_q_final", q, 8'h3C);

        // Set aborts a burst without a done pulse.
        do_op(3'b001, 8'h81);
        start_burst(1'b0, 4'd5);
        tick(); check("bs_r1", q, 8'h03);
        set = 1'b1; tick(); set = 1'b0;
        check("bs_q", q, 8'hFF);
        check("bs_busy", busy, 0);
        check("bs_done", done, 0);
        tick(); check("bs_done2", done, 0);
        check("bs_q2", q, 8'hFF);

        // Reset aborts a burst.
        do_op(3'b001, 8'h81);
        start_burst(1'b0, 4'd5);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("br_q", q, 8'h00);
        check("br_busy", busy, 0);
        tick(); check("br_done", done, 0);
        check("br_q2", q, 8'h00);

        // en=0 and reserved opcode both hold.
        do_op(3'b001, 8'h33);
        en = 1'b0; op = 3'b001; d = 8'h5A; tick(); op = 3'b000;
        check("en0_hold", q, 8'h33);
        do_op(3'b111, 8'h5A);
        check("op7_hold", q, 8'h33);
        check("op7_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded, got no finish expected finish");
        $fatal(1);
    end
endmodule
